pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 78 +++++++
 tb/tb_pipe_stall_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard-driven stall/flush control for the D stage plus multiply/divide busy tracking.
// Stall and E_flush are combinational; md_cnt, md_busy and stall_cnt are registered.
module pipe_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_rs_tuse,
  input  logic [1:0]  D_rt_tuse,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  E_tnew,
  input  logic [1:0]  M_tnew,
  input  logic        D_is_md,
  input  logic [1:0]  E_md_start,
  output logic        Stall,
  output logic        E_flush,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_rs_e, stall_rt_e, stall_rs_m, stall_rt_m, stall_md;
  logic        md_start_any;

  // A producer only blocks when its result arrives later than the consumer needs it.
  always_comb begin
    stall_rs_e   = (D_rs != 5'd0) && (D_rs == E_A3) && (E_tnew > D_rs_tuse);
    stall_rt_e   = (D_rt != 5'd0) && (D_rt == E_A3) && (E_tnew > D_rt_tuse);
    stall_rs_m   = (D_rs != 5'd0) && (D_rs == M_A3) && (M_tnew > D_rs_tuse);
    stall_rt_m   = (D_rt != 5'd0) && (D_rt == M_A3) && (M_tnew > D_rt_tuse);
    md_start_any = (E_md_start == 2'b01) || (E_md_start == 2'b10);
    stall_md     = D_is_md && (md_busy || md_start_any);
    Stall        = stall_rs_e | stall_rt_e | stall_rs_m | stall_rt_m | stall_md;
    E_flush      = Stall;
  end

  // A running count ignores new starts; only an idle unit accepts a load.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (reset) begin
      md_cnt_d = 4'd0;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else if (E_md_start == 2'b01) begin
      md_cnt_d = MULT_LOAD;
    end else if (E_md_start == 2'b10) begin
      md_cnt_d = DIV_LOAD;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      stall_cnt_d = 32'd0;
    end else if (Stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    md_cnt_q    <= md_cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign md_cnt    = md_cnt_q;
  assign md_busy   = (md_cnt_q != 4'd0);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expectations queued at drive time, popped at sample time.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew, E_md_start;
  logic        D_is_md;
  logic        Stall, E_flush, md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .E_A3(E_A3), .M_A3(M_A3), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .D_is_md(D_is_md), .E_md_start(E_md_start),
    .Stall(Stall), .E_flush(E_flush), .md_busy(md_busy),
    .md_cnt(md_cnt), .stall_cnt(stall_cnt)
  );

  task automatic expect_val(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d, no expected value queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", t, obs, e);
      end
    end
  endtask

  task automatic push_exp(input string t, input bit stall, input bit busy,
                          input int cnt, input int sc);
    expect_val({t, ".Stall"}, 32'(stall));
    expect_val({t, ".E_flush"}, 32'(stall));
    expect_val({t, ".md_busy"}, 32'(busy));
    expect_val({t, ".md_cnt"}, 32'(cnt));
    expect_val({t, ".stall_cnt"}, 32'(sc));
  endtask

  task automatic sample();
    #1;
    check_next(32'(Stall));
    check_next(32'(E_flush));
    check_next(32'(md_busy));
    check_next(32'(md_cnt));
    check_next(stall_cnt);
  endtask

  task automatic clear_in();
    D_rs = 5'd0; D_rt = 5'd0; E_A3 = 5'd0; M_A3 = 5'd0;
    D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; E_tnew = 2'd0; M_tnew = 2'd0;
    D_is_md = 1'b0; E_md_start = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    push_exp("reset", 0, 0, 0, 0); sample();

    // Data hazards against E and M.
    @(negedge clk); E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_rs_tuse = 2'd1;
    push_exp("load_use", 1, 0, 0, 0); sample();
    @(negedge clk); E_tnew = 2'd1;
    push_exp("load_use_fwd", 0, 0, 0, 1); sample();
    @(negedge clk); E_tnew = 2'd2; D_rs_tuse = 2'd2;
    push_exp("tnew_eq_tuse", 0, 0, 0, 1); sample();
    @(negedge clk); clear_in(); E_tnew = 2'd2; D_rs_tuse = 2'd0;
    push_exp("reg0_guard", 0, 0, 0, 1); sample();
    @(negedge clk); clear_in(); M_A3 = 5'd5; M_tnew = 2'd2; D_rt = 5'd5; D_rt_tuse = 2'd1;
    push_exp("rt_vs_m", 1, 0, 0, 1); sample();
    @(negedge clk); clear_in(); E_md_start = 2'b11; D_is_md = 1'b1;
    push_exp("md_start_11", 0, 0, 0, 2); sample();

    // Mult with a waiting md instruction in D.
    @(negedge clk); clear_in(); reset = 1'b1;
    push_exp("reset2", 0, 0, 0, 2); sample();
    @(negedge clk); reset = 1'b0; E_md_start = 2'b01; D_is_md = 1'b1;
    push_exp("mult_start", 1, 0, 0, 0); sample();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); E_md_start = 2'b00;
      push_exp("mult_busy", 1, 1, 6 - i, i); sample();
    end
    @(negedge clk);
    push_exp("mult_issue", 0, 0, 0, 6); sample();

    // Div request while mult is running is ignored.
    @(negedge clk); clear_in(); E_md_start = 2'b01;
    push_exp("mult2_start", 0, 0, 0, 6); sample();
    @(negedge clk); E_md_start = 2'b00;
    push_exp("mult2_5", 0, 1, 5, 6); sample();
    @(negedge clk);
    push_exp("mult2_4", 0, 1, 4, 6); sample();
    @(negedge clk); E_md_start = 2'b10;
    push_exp("div_while_busy", 0, 1, 3, 6); sample();
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk); E_md_start = 2'b00;
      push_exp("no_reload", 0, i != 0, i, 6); sample();
    end

    // Reset mid-div with a data hazard present during the reset cycle.
    @(negedge clk); E_md_start = 2'b10;
    push_exp("div_start", 0, 0, 0, 6); sample();
    for (int i = 10; i >= 8; i--) begin
      @(negedge clk); E_md_start = 2'b00;
      push_exp("div_busy", 0, 1, i, 6); sample();
    end
    @(negedge clk); reset = 1'b1; E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_rs_tuse = 2'd1;
    push_exp("reset_mid_div", 1, 1, 7, 6); sample();
    @(negedge clk); reset = 1'b0; clear_in();
    push_exp("after_reset", 0, 0, 0, 0); sample();

    // Simultaneous data and MD hazards count once per cycle.
    @(negedge clk); E_md_start = 2'b01;
    push_exp("comb_start", 0, 0, 0, 0); sample();
    @(negedge clk); E_md_start = 2'b00; M_A3 = 5'd9; M_tnew = 2'd1; D_rt = 5'd9;
    D_rt_tuse = 2'd0; D_is_md = 1'b1;
    push_exp("combined", 1, 1, 5, 0); sample();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      push_exp("combined_cnt", 1, 1, 5 - i, i); sample();
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
